steer_pipe: RTL and testbench
=============================

Name: steer_pipe

Overview:
- Parametrised, registered successor to the single-flit permutation-stage steering function.
- Computes the desired output port (0/1) for NUM_CH flits in parallel at a selectable permutation stage.
- Stage-to-direction grouping is programmable, and ties between groups are broken with per-channel alternation for fairness.
- Sits between route computation (productive vectors) and the 2x2 permuter-stage arbiters, with a valid/ready handshake so the router pipeline can stall.

Parameters:
- NUM_DIR, 4, width of each productive vector (bit0=N, 1=E, 2=S, 3=W).
- NUM_STAGE, 2, number of permutation stages supported.
- NUM_CH, 4, flits steered in parallel.
- HIGH_MASK, 8'b1010_0011, NUM_STAGE*NUM_DIR bits; slice [s*NUM_DIR +: NUM_DIR] marks the directions steered to port 1 at stage s. All other directions steer to port 0.
- CNT_W, 16, statistics counter width (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input bundle valid.
- in_ready  out  1  block accepts the bundle this cycle.
- stage  in  max(1,$clog2(NUM_STAGE))  stage index for this bundle.
- prod_vec  in  NUM_CH*NUM_DIR  per-channel productive vectors; channel c = [c*NUM_DIR +: NUM_DIR].
- out_valid  out  1  output bundle valid.
- out_ready  in  1  downstream accepts the output.
- desire_port  out  NUM_CH  per-channel desired port.
- stage_out  out  width of stage  registered copy of stage.
- conflict_cnt  out  CNT_W  saturating tie count (present only with STEER_STATS_EN).

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: out_valid=0, desire_port=0, stage_out=0, all tie toggles=0, conflict_cnt=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready.
  - On accept, the output registers load next cycle and out_valid=1. Latency is 1 cycle.
  - If out_valid && !out_ready, all outputs hold stable and no input is accepted.
  - If out_valid && out_ready && !in_valid, out_valid falls to 0 next cycle.
  - Back-to-back accepts give full throughput.
- Stage range: a stage value >= NUM_STAGE is clamped to NUM_STAGE-1.
- Per channel c, with m = HIGH_MASK slice for the stage:
  - hi = |(prod_vec_c & m); lo = |(prod_vec_c & ~m).
  - hi && !lo: port 1.
  - lo && !hi: port 0.
  - hi && lo (tie): port = toggle_c, then toggle_c inverts. The toggle updates only on accept.
  - !hi && !lo (empty vector): port = the previous desire_port_c. This register replaces the level-sensitive hold of the earlier design; no latches are permitted.
- Channels are fully independent. Toggles are never changed by stalls or by cycles without an accept.
- With default parameters, the mapping matches the earlier single-flit function:
  - stage 0: N/E → 1, S/W → 0;
  - stage 1: E/W → 1, N/S → 0.
  - The only difference is ties, which now alternate instead of always choosing 1.
- Reset asserted mid-stall: outputs and toggles clear next edge, and the pending bundle is dropped.

Optional Feature:
- Macro: STEER_STATS_EN.
- Defined:
  - conflict_cnt port exists.
  - On each accept, conflict_cnt adds the number of tie channels in that bundle.
  - The count saturates at 2^CNT_W-1 and never wraps.
  - Cleared by reset.
- Undefined: port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Defaults, stage=0, ch0 vec=4'b0001, ch1=4'b0100, ch2=4'b0010, ch3=4'b1000, held in_valid=1, out_ready=1 -> one cycle later desire_port=4'b0101, out_valid=1.
- Stage=1, all channels vec=4'b0101 (N+S) -> desire_port=4'b0000. Then all vec=4'b1000 -> 4'b1111.
- Tie: stage=0, ch0 vec=4'b0101 on three consecutive accepts -> ch0 port 0,1,0; toggle unchanged across inserted idle cycles.
- Empty vector: ch2 gets 4'b0010 (port 1), then 4'b0000 -> ch2 stays 1. After reset, with vec 0 -> 0.
- Stall: out_ready=0 for 3 cycles with new in_valid bundles -> in_ready=0, desire_port stable, no toggle change. Release -> queued bundle appears next cycle.
- STEER_STATS_EN, CNT_W=4: 5 bundles each with 4 ties (4'b1111 all channels) -> counter 4,8,12,15,15 (saturated). Reset -> 0.

Source files
------------

// File: rtl/steer_pipe.sv
// steer_pipe: registered NUM_CH-wide permutation-stage port steering with valid/ready; STEER_STATS_EN adds a saturating tie counter
module steer_pipe #(
  parameter int NUM_DIR = 4,
  parameter int NUM_STAGE = 2,
  parameter int NUM_CH = 4,
  parameter logic [NUM_STAGE*NUM_DIR-1:0] HIGH_MASK = 8'b1010_0011,
  parameter int CNT_W = 16,
  localparam int SW = (NUM_STAGE > 1) ? $clog2(NUM_STAGE) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SW-1:0]             stage,
  input  logic [NUM_CH*NUM_DIR-1:0] prod_vec,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_CH-1:0]         desire_port,
  output logic [SW-1:0]             stage_out
`ifdef STEER_STATS_EN
  ,
  output logic [CNT_W-1:0]          conflict_cnt
`endif
);
  logic                out_valid_q;
  logic [NUM_CH-1:0]   desire_q, desire_d, toggle_q, toggle_d, hi, lo;
  logic [SW-1:0]       stage_q, stage_cl;
  logic [NUM_DIR-1:0]  m;
  logic                accept;
  assign in_ready    = !out_valid_q || out_ready;
  assign accept      = in_valid && in_ready;
  assign stage_cl    = (32'(stage) >= NUM_STAGE) ? SW'(NUM_STAGE - 1) : stage;
  assign m           = HIGH_MASK[stage_cl*NUM_DIR +: NUM_DIR];
  assign out_valid   = out_valid_q;
  assign desire_port = desire_q;
  assign stage_out   = stage_q;
  // per-channel group classification; ties take the channel toggle, empty vectors keep the last port
  always_comb begin
    hi = '0;
    lo = '0;
    desire_d = desire_q;
    toggle_d = toggle_q;
    for (int c = 0; c < NUM_CH; c++) begin
      hi[c] = |(prod_vec[c*NUM_DIR +: NUM_DIR] & m);
      lo[c] = |(prod_vec[c*NUM_DIR +: NUM_DIR] & ~m);
      desire_d[c] = (hi[c] && lo[c]) ? toggle_q[c] : hi[c] ? 1'b1 : lo[c] ? 1'b0 : desire_q[c];
      toggle_d[c] = toggle_q[c] ^ (hi[c] && lo[c]);
    end
  end
`ifdef STEER_STATS_EN
  localparam int TW = $clog2(NUM_CH + 1);
  logic [TW-1:0]    ties;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign conflict_cnt = cnt_q;
  // tie population of the incoming bundle added with saturation
  always_comb begin
    ties = '0;
    for (int c = 0; c < NUM_CH; c++) ties = ties + TW'(hi[c] & lo[c]);
    sum = {1'b0, cnt_q} + (CNT_W+1)'(ties);
    cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end
  // statistics register advances only on accepted bundles
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else if (accept) cnt_q <= cnt_d;
  end
`endif
  // output stage: load on accept, drain when downstream takes it, hold while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      desire_q    <= '0;
      toggle_q    <= '0;
      stage_q     <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      desire_q    <= desire_d;
      toggle_q    <= toggle_d;
      stage_q     <= stage;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_steer_pipe.sv
// tb_steer_pipe: directed and random checks of steer_pipe against a direction-table model
module tb_steer_pipe;
`ifdef STEER_STATS_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif
  logic clk = 0, reset = 0, in_valid = 0, in_ready, stage = 0, out_valid, out_ready = 1, stage_out;
  logic [15:0] prod_vec = '0;
  logic [3:0]  desire_port;
`ifdef STEER_STATS_EN
  logic [CW-1:0] conflict_cnt;
`endif
  int passed = 0, total = 0;
  bit ev = 0, es = 0;
  bit [3:0] ep = 0, et = 0;
  int ecnt = 0;
  int unsigned tbl [2][4] = '{'{1, 1, 0, 0}, '{0, 1, 0, 1}};

  steer_pipe #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .stage(stage),
    .prod_vec(prod_vec), .out_valid(out_valid), .out_ready(out_ready),
    .desire_port(desire_port), .stage_out(stage_out)
`ifdef STEER_STATS_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
  endtask

  task automatic cyc(bit v, bit s, logic [15:0] pv, bit ordy);
    int ties;
    in_valid = v; stage = s; prod_vec = pv; out_ready = ordy;
    @(negedge clk);
    chk("in_ready", in_ready, !ev || ordy);
    @(posedge clk);
    if (reset) begin
      ev = 0; es = 0; ep = 0; et = 0; ecnt = 0;
    end else if (v && (!ev || ordy)) begin
      ties = 0;
      for (int c = 0; c < 4; c++) begin
        bit [1:0] seen = 0;
        for (int d = 0; d < 4; d++) if (pv[c*4+d]) seen[tbl[s][d]] = 1;
        if (seen == 2'b11) begin ep[c] = et[c]; et[c] = ~et[c]; ties++; end
        else if (seen == 2'b10) ep[c] = 1;
        else if (seen == 2'b01) ep[c] = 0;
      end
      ev = 1; es = s;
      ecnt = (ecnt + ties > 2**CW - 1) ? 2**CW - 1 : ecnt + ties;
    end else if (ordy) ev = 0;
    #1;
    chk("out_valid", out_valid, ev);
    chk("desire_port", desire_port, ep);
    chk("stage_out", stage_out, es);
`ifdef STEER_STATS_EN
    chk("conflict_cnt", conflict_cnt, ecnt);
`endif
  endtask

  task automatic do_reset();
    reset = 1;
    cyc(0, 0, '0, 1);
    reset = 0;
  endtask

  initial begin
    do_reset();
    chk("reset_valid", out_valid, 0);
    chk("reset_port", desire_port, 0);
    cyc(1, 0, 16'h8241, 1);
    chk("map_stage0", desire_port, 4'b0101);
    cyc(1, 1, 16'h5555, 1);
    chk("map_stage1_ns", desire_port, 4'b0000);
    cyc(1, 1, 16'h8888, 1);
    chk("map_stage1_w", desire_port, 4'b1111);
    cyc(0, 0, '0, 1);
    chk("drain", out_valid, 0);
    do_reset();
    cyc(1, 0, 16'h0005, 1);
    chk("tie0", desire_port[0], 0);
    cyc(0, 0, '0, 1);
    cyc(0, 0, 16'h0005, 1);
    cyc(1, 0, 16'h0005, 1);
    chk("tie1", desire_port[0], 1);
    cyc(0, 0, '0, 1);
    cyc(1, 0, 16'h0005, 1);
    chk("tie2", desire_port[0], 0);
    do_reset();
    cyc(1, 0, 16'h0200, 1);
    chk("empty_set", desire_port[2], 1);
    cyc(1, 0, 16'h0000, 1);
    chk("empty_hold", desire_port[2], 1);
    do_reset();
    cyc(1, 0, 16'h0000, 1);
    chk("empty_after_reset", desire_port, 0);
    cyc(1, 0, 16'h8241, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 16'h8888, 0);
      chk("stall_port", desire_port, 4'b0101);
    end
    cyc(1, 1, 16'h8888, 1);
    chk("stall_release", desire_port, 4'b1111);
    cyc(1, 0, 16'h0005, 0);
    reset = 1;
    cyc(1, 0, 16'h0005, 0);
    reset = 0;
    cyc(0, 0, '0, 1);
    chk("reset_drop", out_valid, 0);
`ifdef STEER_STATS_EN
    do_reset();
    for (int i = 0; i < 5; i++) begin
      int unsigned exp_c;
      exp_c = (4*(i+1) > 15) ? 15 : 4*(i+1);
      cyc(1, 0, 16'hFFFF, 1);
      chk("sat_cnt", conflict_cnt, exp_c);
    end
    do_reset();
    chk("cnt_reset", conflict_cnt, 0);
`endif
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      cyc($urandom_range(0, 3) != 0, 1'($urandom), 16'($urandom & $urandom), $urandom_range(0, 3) != 0);
      reset = 0;
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
